// File: rtl/active_low_enc_pkg.sv
// Shared constants, FSM state type, event payload and encode helpers for the active-low 4-to-2 encoder.
// ACTIVE_LOW_ENC_MULTI_DETECT_EN adds a multi-request flag to the event payload.
package active_low_enc_pkg;

   localparam int unsigned NUM_LINES   = 4;
   localparam int unsigned CODE_W      = 2;
   localparam int unsigned SYNC_STAGES = 2;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      DEBOUNCE     = 2'd1,
      VALID        = 2'd2,
      WAIT_RELEASE = 2'd3
   } state_e;

   typedef struct packed {
      logic [CODE_W-1:0] code;
`ifdef ACTIVE_LOW_ENC_MULTI_DETECT_EN
      logic              multi;
`endif
   } enc_evt_t;

   // Highest-index active request wins
   function automatic logic [CODE_W-1:0] prio_encode(input logic [NUM_LINES-1:0] req);
      logic [CODE_W-1:0] code;
      code = '0;
      for (int unsigned i = 0; i < NUM_LINES; i++) begin
         if (req[i]) code = CODE_W'(i);
      end
      return code;
   endfunction

   function automatic logic multi_hot(input logic [NUM_LINES-1:0] req);
      int unsigned n;
      n = 0;
      for (int unsigned i = 0; i < NUM_LINES; i++) begin
         if (req[i]) n++;
      end
      return (n > 1);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Multi-stage synchronizer for asynchronous active-low inputs; flops reset to 1 (inactive).
module sync_2ff
   import active_low_enc_pkg::*;
#(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage_q [SYNC_STAGES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) stage_q[i] <= '1;
      end else begin
         stage_q[0] <= d;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/active_low_4_to_2_encoder.sv
// Debounced active-low 4-to-2 priority encoder with valid/ack handshake.
// ACTIVE_LOW_ENC_MULTI_DETECT_EN adds the 'multi' output.
module active_low_4_to_2_encoder
   import active_low_enc_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned CNT_W           = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_LINES-1:0] D_n,
   input  logic                 EN_n,
   input  logic                 ack,
   output logic                 A,
   output logic                 B,
   output logic                 valid,
   output logic                 gs_n
`ifdef ACTIVE_LOW_ENC_MULTI_DETECT_EN
  ,output logic                 multi
`endif
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [NUM_LINES:0]   sync_q;
   logic [NUM_LINES-1:0] req;
   logic                 any;
   logic [CODE_W-1:0]    code_c;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CODE_W-1:0] cand_q, cand_d;
   enc_evt_t          evt_q, evt_d;
   logic              valid_q, valid_d;
   logic              gs_n_q, gs_n_d;

   sync_2ff #(.WIDTH(NUM_LINES + 1)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     ({EN_n, D_n}),
      .q     (sync_q)
   );

   assign req    = ~sync_q[NUM_LINES-1:0] & {NUM_LINES{~sync_q[NUM_LINES]}};
   assign any    = |req;
   assign code_c = prio_encode(req);

   // Next-state and next-output logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cand_d  = cand_q;
      evt_d   = evt_q;
      valid_d = valid_q;
      gs_n_d  = ~any;

      case (state_q)
         IDLE: begin
            if (any) begin
               state_d = DEBOUNCE;
               cand_d  = code_c;
               cnt_d   = CNT_ONE;
            end
         end
         DEBOUNCE: begin
            if (!any) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (code_c != cand_q) begin
               cand_d = code_c;
               cnt_d  = CNT_ONE;
            end else if (cnt_q == CNT_LAST) begin
               state_d    = VALID;
               evt_d.code = cand_q;
`ifdef ACTIVE_LOW_ENC_MULTI_DETECT_EN
               evt_d.multi = multi_hot(req);
`endif
               valid_d    = 1'b1;
               cnt_d      = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         VALID: begin
            // Inputs are ignored here so an accepted event is never lost
            if (ack) begin
               state_d = WAIT_RELEASE;
               valid_d = 1'b0;
               cnt_d   = '0;
`ifdef ACTIVE_LOW_ENC_MULTI_DETECT_EN
               evt_d.multi = 1'b0;
`endif
            end
         end
         WAIT_RELEASE: begin
            if (any) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         cand_q  <= '0;
         evt_q   <= '0;
         valid_q <= 1'b0;
         gs_n_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cand_q  <= cand_d;
         evt_q   <= evt_d;
         valid_q <= valid_d;
         gs_n_q  <= gs_n_d;
      end
   end

   assign A     = evt_q.code[1];
   assign B     = evt_q.code[0];
   assign valid = valid_q;
   assign gs_n  = gs_n_q;
`ifdef ACTIVE_LOW_ENC_MULTI_DETECT_EN
   assign multi = evt_q.multi;
`endif

endmodule

// File: tb/tb_active_low_4_to_2_encoder.sv
// Scoreboard bench for active_low_4_to_2_encoder: directed test-plan cases followed by random presses.
module tb_active_low_4_to_2_encoder;

   localparam int DEB = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] D_n = 4'h0;
   logic       EN_n = 1'b0;
   logic       ack = 1'b0;
   logic       A, B, valid, gs_n;
`ifdef ACTIVE_LOW_ENC_MULTI_DETECT_EN
   logic       multi;
`endif

   always #5 clk = ~clk;

   active_low_4_to_2_encoder #(.DEBOUNCE_CYCLES(DEB), .CNT_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .D_n   (D_n),
      .EN_n  (EN_n),
      .ack   (ack),
      .A     (A),
      .B     (B),
      .valid (valid),
      .gs_n  (gs_n)
`ifdef ACTIVE_LOW_ENC_MULTI_DETECT_EN
     ,.multi (multi)
`endif
   );

   int n_cmp = 0;
   int n_bad = 0;

   function automatic void check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   // Reference model: inputs reach the decision logic two edges late; an event is a run of
   // DEB identical non-zero codes while armed, re-arming needs DEB quiet samples after ack.
   typedef struct { logic [1:0] code; logic multi; } exp_t;
   typedef enum { ARMED, HELD, RELEASING } phase_t;

   exp_t       sb_q[$];
   logic [4:0] hist[$];
   phase_t     ph;
   int         run_len, quiet;
   logic [1:0] run_code;
   logic       exp_valid, exp_gs_n, exp_multi;
   logic [1:0] exp_code;

   function automatic void model_reset();
      hist.delete();
      hist.push_back(5'h1F);
      hist.push_back(5'h1F);
      sb_q.delete();
      ph = ARMED;
      run_len = 0;
      quiet = 0;
      run_code = 2'd0;
      exp_valid = 1'b0;
      exp_gs_n = 1'b1;
      exp_multi = 1'b0;
      exp_code = 2'd0;
   endfunction

   function automatic void model_step(input logic [4:0] cur, input logic ack_now);
      logic [4:0] eff;
      logic [3:0] req;
      logic [1:0] c;
      eff = hist.pop_front();
      hist.push_back(cur);
      req = eff[4] ? 4'b0000 : ~eff[3:0];
      exp_gs_n = (req == 4'b0000);
      c = 2'($clog2(int'(req) + 1) - 1);
      case (ph)
         ARMED: begin
            if (req != 4'b0000) begin
               if (run_len > 0 && c == run_code) run_len++;
               else begin
                  run_code = c;
                  run_len = 1;
               end
               if (run_len == DEB) begin
                  ph = HELD;
                  exp_valid = 1'b1;
                  exp_code = c;
                  exp_multi = ($countones(req) > 1);
                  sb_q.push_back('{c, ($countones(req) > 1)});
               end
            end else begin
               run_len = 0;
            end
         end
         HELD: begin
            if (ack_now) begin
               ph = RELEASING;
               quiet = 0;
               exp_valid = 1'b0;
               exp_multi = 1'b0;
            end
         end
         RELEASING: begin
            if (req != 4'b0000) quiet = 0;
            else begin
               quiet++;
               if (quiet == DEB) begin
                  ph = ARMED;
                  run_len = 0;
               end
            end
         end
      endcase
   endfunction

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else model_step({EN_n, D_n}, ack);
      end
   end

   // Monitor: per-cycle output check plus scoreboard pop on each new event
   logic prev_valid = 1'b0;
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         check("gs_n", int'(gs_n), int'(exp_gs_n));
         check("valid", int'(valid), int'(exp_valid));
         check("code", int'({A, B}), int'(exp_code));
`ifdef ACTIVE_LOW_ENC_MULTI_DETECT_EN
         check("multi", int'(multi), int'(exp_multi));
`endif
         if (valid && !prev_valid) begin
            if (sb_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL sb_unexpected: got event code %0d, expected none at %0t", {A, B}, $time);
            end else begin
               e = sb_q.pop_front();
               check("sb_code", int'({A, B}), int'(e.code));
`ifdef ACTIVE_LOW_ENC_MULTI_DETECT_EN
               check("sb_multi", int'(multi), int'(e.multi));
`endif
            end
         end
         prev_valid = valid;
      end
   end

   // ackm: 0 = ack low, 1 = ack high, 2 = random each cycle
   task automatic hold(input logic [3:0] d, input logic en, input int n, input int ackm);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         D_n = d;
         EN_n = en;
         ack = (ackm == 2) ? 1'($urandom_range(0, 1)) : (ackm == 1);
      end
   endtask

   initial begin
      // Reset with all lines pressed
      repeat (3) @(negedge clk);
      check("rst_A", int'(A), 0);
      check("rst_B", int'(B), 0);
      check("rst_valid", int'(valid), 0);
      check("rst_gs_n", int'(gs_n), 1);
      @(negedge clk);
      rst_n = 1'b1;
      D_n = 4'hF;
      hold(4'hF, 1'b0, 4, 0);
      check("post_rst_valid", int'(valid), 0);
      check("post_rst_gs_n", int'(gs_n), 1);

      // Single press D2: valid high after the sixth edge
      hold(4'b1011, 1'b0, 6, 0);
      check("lat_before", int'(valid), 0);
      @(negedge clk);
      check("lat_valid", int'(valid), 1);
      check("lat_code", int'({A, B}), 2);
      hold(4'b1011, 1'b0, 10, 0);
      check("held_valid", int'(valid), 1);
      hold(4'b1011, 1'b0, 1, 1);
      hold(4'b1111, 1'b0, 1, 0);
      check("acked_valid", int'(valid), 0);
      hold(4'b1111, 1'b0, 10, 0);

      // Priority with two lines, then a single line
      hold(4'b0110, 1'b0, 12, 2);
      hold(4'b1111, 1'b0, 12, 1);
      hold(4'b1101, 1'b0, 12, 2);
      hold(4'b1111, 1'b0, 12, 1);

      // Short glitch produces no event
      hold(4'b1110, 1'b0, 3, 0);
      hold(4'b1111, 1'b0, 12, 0);

      // Long hold, bouncy release, second press
      hold(4'b1101, 1'b0, 50, 1);
      hold(4'b1111, 1'b0, 2, 0);
      hold(4'b1101, 1'b0, 1, 0);
      hold(4'b1111, 1'b0, 3, 0);
      hold(4'b1101, 1'b0, 1, 0);
      hold(4'b1111, 1'b0, 10, 0);
      hold(4'b1101, 1'b0, 10, 1);
      hold(4'b1111, 1'b0, 10, 0);

      // Enable masks everything
      hold(4'b0000, 1'b1, 20, 1);

      // Reset while an event is pending
      hold(4'b0111, 1'b0, 10, 0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_valid", int'(valid), 0);
      check("midrst_gs_n", int'(gs_n), 1);
      hold(4'b1111, 1'b0, 2, 0);
      @(negedge clk);
      rst_n = 1'b1;
      hold(4'b1111, 1'b0, 6, 0);

      // Random presses and acks
      repeat (300) begin
         hold(4'($urandom_range(0, 15)), ($urandom_range(0, 5) == 0),
              int'($urandom_range(1, 8)), 2);
      end
      hold(4'hF, 1'b0, 20, 1);
      check("sb_leftover", sb_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
